// File: rtl/quadra_out.sv
// Output conditioning for the quadra evaluator: round-half-up, saturate, 2-entry skid FIFO
// and a saturating clip counter.
module quadra_out #(
    parameter int unsigned IN_W  = 24,
    parameter int unsigned OUT_W = 16,
    parameter int unsigned SHIFT = 6,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IN_W-1:0]  in_y,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [OUT_W-1:0] out_y,
    output logic             out_sat,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] sat_cnt
);

    localparam int unsigned RW = IN_W + 1 - SHIFT;
    localparam logic [IN_W:0] Half = (IN_W + 1)'(1) << (SHIFT - 1);
    localparam logic [OUT_W-1:0] MaxPos = {1'b0, {(OUT_W - 1){1'b1}}};
    localparam logic [OUT_W-1:0] MinNeg = {1'b1, {(OUT_W - 1){1'b0}}};

    logic [IN_W:0]      ext, sum;
    logic [RW-1:0]      r;
    logic [RW-OUT_W:0]  hi;
    logic               sat;
    logic [OUT_W-1:0]   val;

    // Bits above the output sign must all match the sign for the value to fit.
    always_comb begin
        ext = {in_y[IN_W-1], in_y};
        sum = ext + Half;
        r   = sum[IN_W:SHIFT];
        hi  = r[RW-1:OUT_W-1];
        sat = !((&hi) || !(|hi));
        if (sat) begin
            val = r[RW-1] ? MinNeg : MaxPos;
        end else begin
            val = r[OUT_W-1:0];
        end
    end

    logic [OUT_W-1:0] mem_q [2];
    logic [1:0]       sat_mem_q;
    logic             wr_ptr_q, rd_ptr_q;
    logic [1:0]       count_q, count_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             push, pop;

    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_y     = out_valid ? mem_q[rd_ptr_q] : '0;
    assign out_sat   = out_valid ? sat_mem_q[rd_ptr_q] : 1'b0;
    assign sat_cnt   = cnt_q;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (push && sat && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_q[0]  <= '0;
            mem_q[1]  <= '0;
            sat_mem_q <= '0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
            cnt_q     <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q]     <= val;
                sat_mem_q[wr_ptr_q] <= sat;
                wr_ptr_q            <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
